modn_updown_counter: RTL and testbench

- Parametrised synchronous up/down modulo-N counter; next generation of the team's 4-bit LS163-style counter.
- Generalised in width and modulus, with a direction control and a registered wrap flag.
- Keeps the LS163 ent/enp cascade semantics and combinational ripple-carry output, so multi-digit chains (decade, mod-60, etc.) are built by tying rco to the next stage's ent.
- Used in timer and display-digit chains.

---
 rtl/modn_updown_counter.sv | 93 +++++++++
 tb/tb_modn_updown_counter.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/modn_updown_counter.sv
// Parametrised synchronous up/down modulo-N counter with LS163-style ent/enp cascade and combinational rco.
// Define MODN_COUNTER_SATURATE_EN to make the count saturate at its end values instead of wrapping (wrap then stays 0).
module modn_updown_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             load,
  input  logic             ent,
  input  logic             enp,
  input  logic             up,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             rco,
  output logic             wrap
);

  generate
    if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
      $error("modn_updown_counter: WIDTH %0d outside 1..16", WIDTH);
    end
    if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
      $error("modn_updown_counter: MODULUS %0d outside 2..2**WIDTH", MODULUS);
    end
  endgenerate

  localparam logic [WIDTH-1:0] LAST    = WIDTH'(MODULUS - 1);
  // One extra bit so MODULUS == 2**WIDTH is representable and over_range is then never true.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

`ifdef MODN_COUNTER_SATURATE_EN
  localparam logic [WIDTH-1:0] TOP_NEXT = LAST;
  localparam logic [WIDTH-1:0] BOT_NEXT = '0;
  localparam logic             WRAP_EN  = 1'b0;
`else
  localparam logic [WIDTH-1:0] TOP_NEXT = '0;
  localparam logic [WIDTH-1:0] BOT_NEXT = LAST;
  localparam logic             WRAP_EN  = 1'b1;
`endif

  logic             at_top;
  logic             at_zero;
  logic             over_range;
  logic [WIDTH-1:0] q_next;
  logic             wrap_next;
  logic             wrap_q;

  assign at_top     = (q >= LAST);
  assign at_zero    = (q == '0);
  assign over_range = ({1'b0, q} >= MOD_EXT);

  // ent enters rco through a single AND so cascades see no ent-induced glitch.
  assign rco  = ent & (up ? at_top : at_zero);
  assign wrap = WRAP_EN & wrap_q;

  always_comb begin
    q_next    = q;
    wrap_next = 1'b0;
    if (!load) begin
      q_next = d;
    end else if (ent && enp) begin
      if (up) begin
        if (at_top) begin
          q_next    = TOP_NEXT;
          wrap_next = WRAP_EN;
        end else begin
          q_next = q + 1'b1;
        end
      end else begin
        if (at_zero) begin
          q_next    = BOT_NEXT;
          wrap_next = WRAP_EN;
        end else if (over_range) begin
          q_next = LAST;
        end else begin
          q_next = q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!clear) begin
      q      <= '0;
      wrap_q <= 1'b0;
    end else begin
      q      <= q_next;
      wrap_q <= wrap_next;
    end
  end

endmodule

// File: tb/tb_modn_updown_counter.sv
// Bench for modn_updown_counter: directed literal checks, a mod-60 cascade, and randomized traffic
// compared every cycle against an integer model of the counting rules.
module tb_modn_updown_counter;

  localparam int M = 10;

  logic       clk;
  logic       clear, load, ent, enp, up;
  logic [3:0] d;
  logic [3:0] q;
  logic       rco, wrap;

  logic       c_clear;
  logic [3:0] c1_q, c2_q;
  logic       c1_rco, c2_rco, c1_wrap, c2_wrap;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int mq;
  bit mw;
  bit m_valid = 0;

  modn_updown_counter #(.WIDTH(4), .MODULUS(M)) dut (
    .clk(clk), .clear(clear), .load(load), .ent(ent), .enp(enp), .up(up),
    .d(d), .q(q), .rco(rco), .wrap(wrap)
  );

  modn_updown_counter #(.WIDTH(4), .MODULUS(10)) stage1 (
    .clk(clk), .clear(c_clear), .load(1'b1), .ent(1'b1), .enp(1'b1), .up(1'b1),
    .d(4'd0), .q(c1_q), .rco(c1_rco), .wrap(c1_wrap)
  );

  modn_updown_counter #(.WIDTH(4), .MODULUS(6)) stage2 (
    .clk(clk), .clear(c_clear), .load(1'b1), .ent(c1_rco), .enp(1'b1), .up(1'b1),
    .d(4'd0), .q(c2_q), .rco(c2_rco), .wrap(c2_wrap)
  );

  // clock
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, check rco in-cycle, advance the model, check q/wrap after the edge.
  task automatic step(input bit c, input bit l, input bit e, input bit p, input bit u,
                      input logic [3:0] dv);
    int exp_rco;
    @(negedge clk);
    clear = c; load = l; ent = e; enp = p; up = u; d = dv;
    #1;
    if (m_valid) begin
      exp_rco = e && (u ? (mq >= M - 1) : (mq == 0));
      check("rco", {15'd0, rco}, 16'(exp_rco));
    end
    if (!c) begin
      mq = 0; mw = 0; m_valid = 1;
    end else if (!l) begin
      mq = int'(dv); mw = 0;
    end else if (e && p) begin
      if (u) begin
        mw = (mq >= M - 1);
        mq = mw ? 0 : mq + 1;
      end else if (mq == 0) begin
        mq = M - 1; mw = 1;
      end else begin
        mq = (mq >= M) ? M - 1 : mq - 1; mw = 0;
      end
    end else begin
      mw = 0;
    end
    @(posedge clk);
    #1;
    if (m_valid) begin
      check("q", {12'd0, q}, 16'(mq));
      check("wrap", {15'd0, wrap}, {15'd0, mw});
    end
  endtask

  initial begin
    int c2_pulses, c1_pulses;
    clear = 0; load = 1; ent = 0; enp = 0; up = 1; d = 0;
    c_clear = 0;

    // cascade: stage2 counts tens of a 0..59 count
    @(negedge clk);
    @(negedge clk);
    check("casc_reset", {4'd0, c2_q, 4'd0, c1_q}, 16'h0000);
    c_clear = 1;
    c1_pulses = 0; c2_pulses = 0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk);
      #1;
      check("casc_units", {12'd0, c1_q}, 16'(i % 10));
      check("casc_tens", {12'd0, c2_q}, 16'((i % 60) / 10));
      c1_pulses += int'(c1_wrap);
      c2_pulses += int'(c2_wrap);
    end
    check("casc_tens_wraps", 16'(c2_pulses), 16'd1);
    check("casc_unit_wraps", 16'(c1_pulses), 16'd6);

    // reset with load also asserted: clear wins
    step(0, 0, 1, 1, 1, 4'd13);
    check("reset_q", {12'd0, q}, 16'd0);
    check("reset_wrap", {15'd0, wrap}, 16'd0);
    // mid-cycle input change does not move q before the edge
    @(negedge clk);
    clear = 1; load = 0; d = 4'd7;
    #2;
    check("no_async", {12'd0, q}, 16'd0);
    step(0, 1, 1, 1, 1, 4'd0);

    // up count 1..9 then wrap to 0
    for (int i = 1; i <= 9; i++) step(1, 1, 1, 1, 1, 4'd0);
    check("up_q9", {12'd0, q}, 16'd9);
    check("rco_at9", {15'd0, rco}, 16'd1);
    step(1, 1, 1, 1, 1, 4'd0);
    check("up_wrap_q", {12'd0, q}, 16'd0);
    check("up_wrap_flag", {15'd0, wrap}, 16'd1);
    step(1, 1, 1, 1, 1, 4'd0);
    check("wrap_one_cycle", {15'd0, wrap}, 16'd0);

    // down count: borrow from 0 to 9
    step(1, 0, 1, 1, 1, 4'd0);
    step(1, 1, 1, 1, 0, 4'd0);
    check("down_borrow_q", {12'd0, q}, 16'd9);
    check("down_borrow_wrap", {15'd0, wrap}, 16'd1);
    for (int i = 0; i < 3; i++) step(1, 1, 1, 1, 0, 4'd0);
    check("down_q6", {12'd0, q}, 16'd6);
    step(1, 0, 1, 1, 0, 4'd0);
    step(1, 1, 0, 1, 0, 4'd0);
    check("ent_low_rco", {15'd0, rco}, 16'd0);
    check("ent_low_hold", {12'd0, q}, 16'd0);

    // enable gating, load priority, out-of-range recovery
    step(1, 0, 1, 1, 1, 4'd5);
    step(1, 1, 1, 0, 1, 4'd0);
    check("enp_hold", {12'd0, q}, 16'd5);
    step(1, 0, 1, 1, 1, 4'd3);
    check("load_over_count", {12'd0, q}, 16'd3);
    step(1, 0, 1, 1, 1, 4'd13);
    check("load_oor", {12'd0, q}, 16'd13);
    step(1, 1, 1, 1, 1, 4'd0);
    check("oor_up", {12'd0, q}, 16'd0);
    step(1, 0, 1, 1, 1, 4'd13);
    step(1, 1, 1, 1, 0, 4'd0);
    check("oor_down_q", {12'd0, q}, 16'd9);
    check("oor_down_wrap", {15'd0, wrap}, 16'd0);

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 31) != 0, $urandom_range(0, 7) != 0,
           $urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0,
           1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
